// File: rtl/quad_mux_arbiter_pkg.sv
// Shared encodings for the two-requester bus arbiter.
// State and owner values are common to the core and its users.
package quad_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    // Owner values line up with mux select polarity (1 = a).
    localparam logic OWNER_A = 1'b1;
    localparam logic OWNER_B = 1'b0;

endpackage

// File: rtl/quad_mux_arbiter_quad_2X1_mux.sv
// 4-bit 2:1 mux with active-high enable and tri-state output.
// Select 1 passes a, 0 passes b; output floats when disabled.
module quad_2X1_mux (
    output wire  [3:0] y,
    input  logic       s,
    input  logic       en,
    input  logic [3:0] a,
    input  logic [3:0] b
);

    assign y = en ? (s ? a : b) : 4'bzzzz;

endmodule

// File: rtl/quad_mux_arbiter.sv
// Round-robin arbiter with hold limit for a shared 4-bit bus.
// Moore grants, select and enable are registered from next state.
module quad_mux_arbiter
    import quad_mux_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int CW       = 3
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       s,
    output logic       en,
    output wire  [3:0] y
);

    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic          r_gnt_a;
    logic          r_gnt_b;
    logic          r_s;
    logic          r_en;
    logic          w_sat;

    assign w_sat = (r_cnt == CNT_MAX);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_a && (!req_b || r_last == OWNER_B))
                    w_next = GNT_A;
                else if (req_b)
                    w_next = GNT_B;
                else
                    w_next = IDLE;
            end
            GNT_A: begin
                if (!req_a)
                    w_next = req_b ? GNT_B : IDLE;
                else if (req_b && w_sat)
                    w_next = GNT_B;
                else
                    w_next = GNT_A;
            end
            GNT_B: begin
                if (!req_b)
                    w_next = req_a ? GNT_A : IDLE;
                else if (req_a && w_sat)
                    w_next = GNT_A;
                else
                    w_next = GNT_B;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= OWNER_B;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_s     <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt_a <= (w_next == GNT_A);
            r_gnt_b <= (w_next == GNT_B);
            r_en    <= (w_next != IDLE);
            if (w_next == IDLE) begin
                r_cnt <= '0;
            end else if (w_next != r_state) begin
                r_cnt  <= '0;
                r_last <= (w_next == GNT_A) ? OWNER_A : OWNER_B;
                r_s    <= (w_next == GNT_A) ? OWNER_A : OWNER_B;
            end else if (!w_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign gnt_a = r_gnt_a;
    assign gnt_b = r_gnt_b;
    assign s     = r_s;
    assign en    = r_en;

    quad_2X1_mux u_mux (
        .y  (y),
        .s  (r_s),
        .en (r_en),
        .a  (a),
        .b  (b)
    );

endmodule

// File: tb/tb_quad_mux_arbiter.sv
// Directed bench for quad_mux_arbiter with HOLD_MAX=4.
// Each scenario task checks its own hand-computed outputs.
module tb_quad_mux_arbiter;

    logic       clock;
    logic       reset_b;
    logic       req_a;
    logic       req_b;
    logic [3:0] a;
    logic [3:0] b;
    logic       gnt_a;
    logic       gnt_b;
    logic       s;
    logic       en;
    wire  [3:0] y;

    int errors;
    int checks;

    quad_mux_arbiter #(.HOLD_MAX(4), .CW(3)) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .req_a   (req_a),
        .req_b   (req_b),
        .a       (a),
        .b       (b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .s       (s),
        .en      (en),
        .y       (y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        a = 4'b0101;
        b = 4'b1010;
        #2;
        checks++;
        if ({gnt_a, gnt_b, s, en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs got=%b exp=0000", {gnt_a, gnt_b, s, en});
        end
        tick();
        tick();
        checks++;
        if ({gnt_a, gnt_b, s, en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held got=%b exp=0000", {gnt_a, gnt_b, s, en});
        end
        checks++;
        if (dut.r_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d exp=0", dut.r_cnt);
        end
        reset_b = 1'b1;
        tick();
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got=%b exp=0", en);
        end
    endtask

    task automatic test_single();
        req_a = 1'b1;
        tick();
        checks++;
        if ({gnt_a, gnt_b, s, en} !== 4'b1011) begin
            errors++;
            $display("FAIL single_a got=%b exp=1011", {gnt_a, gnt_b, s, en});
        end
        checks++;
        if (y !== 4'b0101) begin
            errors++;
            $display("FAIL single_y got=%b exp=0101", y);
        end
    endtask

    task automatic test_release();
        req_a = 1'b0;
        tick();
        checks++;
        if ({gnt_a, gnt_b, en} !== 3'b000) begin
            errors++;
            $display("FAIL release got=%b exp=000", {gnt_a, gnt_b, en});
        end
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL idle_s_hold got=%b exp=1", s);
        end
        checks++;
        if (dut.r_cnt !== 3'd0) begin
            errors++;
            $display("FAIL release_cnt got=%0d exp=0", dut.r_cnt);
        end
    endtask

    task automatic test_tie();
        reset_b = 1'b0;
        #2;
        reset_b = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (r % 2 == 0 && {gnt_a, gnt_b, s} !== 3'b101) begin
                    errors++;
                    $display("FAIL tie_a r=%0d i=%0d got=%b exp=101",
                             r, i, {gnt_a, gnt_b, s});
                end else if (r % 2 == 1 && {gnt_a, gnt_b, s} !== 3'b010) begin
                    errors++;
                    $display("FAIL tie_b r=%0d i=%0d got=%b exp=010",
                             r, i, {gnt_a, gnt_b, s});
                end
            end
        end
        tick();
        checks++;
        if (y !== 4'b1010 || gnt_b !== 1'b1) begin
            errors++;
            $display("FAIL tie_turn_b y=%b gnt_b=%b exp y=1010 gnt_b=1", y, gnt_b);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle got=%b exp=0", en);
        end
    endtask

    task automatic test_handoff();
        req_a = 1'b1;
        tick();
        req_b = 1'b1;
        tick();
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++;
            $display("FAIL handoff_pre got=%b exp=10", {gnt_a, gnt_b});
        end
        req_a = 1'b0;
        tick();
        checks++;
        if ({gnt_a, gnt_b, s, en} !== 4'b0101 || y !== 4'b1010) begin
            errors++;
            $display("FAIL handoff got=%b y=%b exp=0101 y=1010",
                     {gnt_a, gnt_b, s, en}, y);
        end
        checks++;
        if (dut.r_cnt !== 3'd0) begin
            errors++;
            $display("FAIL handoff_cnt got=%0d exp=0", dut.r_cnt);
        end
        req_b = 1'b0;
        tick();
    endtask

    task automatic test_saturated();
        req_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (gnt_a !== 1'b1) begin
                errors++;
                $display("FAIL sat_hold i=%0d got=%b exp=1", i, gnt_a);
            end
        end
        checks++;
        if (dut.r_cnt !== 3'd3) begin
            errors++;
            $display("FAIL sat_cnt got=%0d exp=3", dut.r_cnt);
        end
        req_b = 1'b1;
        tick();
        checks++;
        if ({gnt_a, gnt_b, s} !== 3'b010) begin
            errors++;
            $display("FAIL sat_turn got=%b exp=010", {gnt_a, gnt_b, s});
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        reset_b = 1'b0;
        #1;
        checks++;
        if ({gnt_a, gnt_b, s, en} !== 4'b0000) begin
            errors++;
            $display("FAIL async_rst got=%b exp=0000", {gnt_a, gnt_b, s, en});
        end
        tick();
        @(negedge clock);
        reset_b = 1'b1;
        tick();
        checks++;
        if ({gnt_a, gnt_b, s, en} !== 4'b1011 || y !== 4'b0101) begin
            errors++;
            $display("FAIL async_after got=%b y=%b exp=1011 y=0101",
                     {gnt_a, gnt_b, s, en}, y);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_release();
        test_tie();
        test_handoff();
        test_saturated();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_mux_arbiter.md
# quad_mux_arbiter

Two-requester round-robin arbiter that shares one 4-bit 2:1 multiplexed bus between requester A and requester B. It drives the mux select and active-high enable, and returns one-hot grants. It adds a hold limit, so a requester cannot starve the other. It sits between two 4-bit producers and the shared tri-state bus `y`, which floats when nobody is granted.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive grant cycles for one requester while the other is waiting. Legal range 2–8.
- `CW`, default 3: hold counter width. Must satisfy 2^CW ≥ HOLD_MAX.
- `clock`  in  1  rising-edge clock. This is the block's only clock.
- `reset_b`  in  1  asynchronous, active-low reset.
- `req_a`  in  1  request from A, level-sensitive, held while A wants the bus.
- `req_b`  in  1  request from B, same rules as `req_a`.
- `a`  in  4  data from A.
- `b`  in  4  data from B.
- `gnt_a`  out  1  A owns the bus. Registered.
- `gnt_b`  out  1  B owns the bus. Registered.
- `s`  out  1  mux select: 1 = `a`, 0 = `b`. Registered.
- `en`  out  1  bus enable, equal to `gnt_a | gnt_b`. Registered.
- `y`  out  4  shared bus: `en ? (s ? a : b) : 4'bzzzz`.

## Operation
- FSM states:
  - IDLE: en=0, gnt_a=0, gnt_b=0, s holds its last value.
  - GNT_A: en=1, s=1, gnt_a=1.
  - GNT_B: en=1, s=0, gnt_b=1.
- Outputs are Moore, decoded from registered state. `gnt_a` and `gnt_b` are never high together.
- `last` register: records who was granted most recently. Updated on entry to GNT_A or GNT_B.
- IDLE transitions:
  - req_a only → GNT_A.
  - req_b only → GNT_B.
  - Both requesting → the requester not equal to `last`.
  - Neither → stay in IDLE.
- GNT_A transitions (GNT_B is symmetric):
  - req_a=0 and req_b=1 → GNT_B, direct handoff with no IDLE bubble.
  - req_a=0 and req_b=0 → IDLE.
  - req_a=1, req_b=1, and `cnt == HOLD_MAX-1` → GNT_B (forced turnover).
  - Otherwise stay.
- `cnt` behaviour:
  - Cleared to 0 on every grant entry, including a direct handoff.
  - Increments each cycle the FSM stays in the same grant state.
  - Saturates at HOLD_MAX-1.
  - Held at 0 in IDLE.
- Consequence of saturation: if the holder runs alone past HOLD_MAX-1 and the other requester then asserts, turnover happens on the next edge.
- `y` is combinational from `a`, `b`, `s`, `en`. Data is not registered.

## Timing
- Reset (asynchronous, immediate on reset_b=0):
  - State IDLE.
  - s=0, en=0, gnt_a=0, gnt_b=0, y=zzzz.
  - cnt=0, last=B, so A wins the first tie.
- Reset asserted mid-grant: `en` drops and `y` floats without waiting for a clock edge.
- Grant latency: a request sampled high at edge k yields a grant after edge k, i.e. 1 cycle.
- Release latency: a request dropped before edge k removes the grant after edge k.
- Worst-case wait for a requester while the other holds: HOLD_MAX cycles plus 1 grant-latency cycle.
- Handoff: `s` and the grants switch at the same edge, so `y` switches source with no z gap.
- Inputs are sampled only at rising `clock`. Requesters must hold `req` until they see their grant. Dropping a request before it is granted simply withdraws it.

## Structure
- Shared package `quad_mux_arbiter_pkg` holds:
  - the state encoding constants IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10;
  - the owner encoding OWNER_A=1'b1, OWNER_B=1'b0, which match the `s` polarity.
- One sub-module: `quad_2X1_mux(y, s, en, a, b)`. This is the existing 4-bit 2:1 mux with active-high enable and tri-state output, instantiated unchanged for the bus.
- The arbiter core holds the FSM, `cnt`, and `last`, with next-state logic and output decode.

## Test plan
- Reset and single request:
  - Stimulus: reset_b=0 with a=0101, b=1010; release reset; assert req_a.
  - Response: y=zzzz and en=0 during reset. One edge after req_a: gnt_a=1, s=1, y=0101.
- Tie on first arbitration:
  - Stimulus: from reset, req_a=req_b=1 together.
  - Response: A granted first (last=B). After 4 cycles with HOLD_MAX=4, gnt_b=1, s=0, y=1010. Alternates A,B every 4 cycles while both are held.
- Direct handoff:
  - Stimulus: A granted, req_b=1; drop req_a for one edge.
  - Response: gnt_b=1 at that edge, with no IDLE cycle and no z on y.
- Release to idle:
  - Stimulus: drop the only active request.
  - Response: after one edge, en=0, y=zzzz, gnts=0, cnt=0.
- Saturated holder:
  - Stimulus: A alone granted for 10 cycles, then req_b rises.
  - Response: gnt_b after the next edge.
- Asynchronous reset mid-grant:
  - Stimulus: assert reset_b=0 between clock edges while gnt_b=1.
  - Response: en, gnt_b, and s drop to 0 immediately and y=zzzz. After release with both requesting, A is granted first.
